// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmitter between NUM_REQ byte-stream requesters.
//   Round-robin arbitration happens once per message. The granted requester
//   keeps the UART until its req_last byte has been sent. Bytes are paced off
//   the core's bsy flag. A bsy flag that never rises is recovered after
//   BSY_TIMEOUT cycles.
// Ports
//   clock     system clock, rising edge
//   reset     asynchronous, active-low; clears all state
//   req       per-requester byte available (held until req_ack)
//   req_data  per-requester byte, requester i on [8i+7:8i]
//   req_last  per-requester end-of-message flag for the offered byte
//   req_ack   one-cycle pulse, byte of requester i accepted
//   grant     one-hot UART owner, 0 when idle
//   txce      one-cycle load strobe to the uart core
//   tx        byte to the uart core, held until the next load
//   bsy       uart core transmitter busy
//   active    high from grant until end of message
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned BSY_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 txce,
  output logic [7:0]           tx,
  input  logic                 bsy,
  output logic                 active
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WAIT_W = (BSY_TIMEOUT > 1) ? $clog2(BSY_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(BSY_TIMEOUT - 1);
  localparam logic [7:0]        GAP_MAX  = 8'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_STROBE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              last_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        gap_cnt;

  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_ok;
  logic [7:0]         owner_byte;
  logic [IDX_W-1:0]   owner_next;

  // Scan requesters starting at rr_ptr and wrapping; the first set bit wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    pick_idx    = '0;
    pick_onehot = '0;
    pick_ok     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_ok && req[idx]) begin
        pick_ok          = 1'b1;
        pick_idx         = IDX_W'(idx);
        pick_onehot[idx] = 1'b1;
      end
    end
  end

  assign owner_byte = req_data[{owner, 3'b000} +: 8];
  assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      last_q   <= 1'b0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      req_ack  <= '0;
      grant    <= '0;
      txce     <= 1'b0;
      tx       <= 8'h00;
      active   <= 1'b0;
    end else begin
      req_ack <= '0;
      txce    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req && !bsy) state <= S_ARB;
        end
        S_ARB: begin
          // The request may have vanished since IDLE; fall back rather than grant nobody.
          if (pick_ok) begin
            grant  <= pick_onehot;
            owner  <= pick_idx;
            active <= 1'b1;
            state  <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (req[owner]) begin
            tx      <= owner_byte;
            req_ack <= grant;
            last_q  <= req_last[owner];
            state   <= S_STROBE;
          end
        end
        S_STROBE: begin
          // txce lands one cycle after req_ack so the two never overlap.
          txce     <= 1'b1;
          wait_cnt <= '0;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bsy) begin
            state <= S_WAIT_LO;
          end else if (wait_cnt == WAIT_MAX) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!bsy) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_MAX) begin
            if (last_q) begin
              grant  <= '0;
              active <= 1'b0;
              rr_ptr <= owner_next;
              state  <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           txce;
  logic [7:0]     tx;
  logic           bsy;
  logic           active;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(.NUM_REQ(N), .BSY_TIMEOUT(TO), .GAP_CYCLES(0)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .txce(txce),
    .tx(tx), .bsy(bsy), .active(active)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // uart core model: bsy high for bsy_len cycles after each txce
  bit bsy_mode = 1'b1;
  int bsy_len  = 20;
  int bsy_cnt  = 0;
  always @(posedge clock) begin
    if (bsy_mode && txce) bsy_cnt <= bsy_len;
    else if (bsy_cnt > 0) bsy_cnt <= bsy_cnt - 1;
  end
  assign bsy = (bsy_cnt != 0);

  // requester model: each requester walks its byte table, advancing on req_ack
  logic [7:0]  bytes [N][8];
  int unsigned len [N];
  int unsigned pos [N];
  logic [N-1:0] en  = '0;
  logic [N-1:0] rep = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) pos[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req_ack[i]) begin
          if (rep[i] && pos[i] + 1 >= len[i]) pos[i] <= 0;
          else pos[i] <= pos[i] + 1;
        end
    end
  end

  always_comb begin
    req      = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req[i]            = en[i] && (pos[i] < len[i]);
      req_last[i]       = (pos[i] + 1 == len[i]);
      req_data[8*i +: 8] = (pos[i] < 8) ? bytes[i][pos[i]] : 8'h00;
    end
  end

  // monitor
  int           n_txce = 0;
  int           n_grant = 0;
  logic [7:0]   txce_tx [64];
  int           txce_cyc [64];
  logic [N-1:0] grant_log [16];
  int           ack_cnt [N];
  int           both_err = 0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clock) begin
    if (!reset) begin
      n_txce = 0;
      n_grant = 0;
      both_err = 0;
      prev_grant = '0;
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    end else begin
      if (txce && n_txce < 64) begin
        txce_tx[n_txce]  = tx;
        txce_cyc[n_txce] = cyc;
        n_txce++;
      end
      if (grant != '0 && prev_grant == '0 && n_grant < 16) begin
        grant_log[n_grant] = grant;
        n_grant++;
      end
      for (int i = 0; i < N; i++) if (req_ack[i]) ack_cnt[i]++;
      if (txce && req_ack != '0) both_err++;
      prev_grant = grant;
    end
  end

  task automatic set_msg(input int r, input int unsigned n, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                         input logic rp);
    len[r]      = n;
    bytes[r][0] = b0;
    bytes[r][1] = b1;
    bytes[r][2] = b2;
    bytes[r][3] = b3;
    for (int j = 4; j < 8; j++) bytes[r][j] = 8'h00;
    rep[r] = rp;
  endtask

  task automatic do_reset();
    int t;
    @(negedge clock);
    reset = 1'b0;
    en = '0;
    rep = '0;
    t = 0;
    while (bsy && t < 60) begin
      @(negedge clock);
      t++;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) set_msg(i, 1, 8'hC0 + 8'(i), 8'h00, 8'h00, 8'h00, 1'b0);
    bsy_mode = 1'b1;
    bsy_len  = 20;
    en = 4'b1111;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (txce !== 1'b0) begin errors++; $display("FAIL reset_txce got=%b exp=0", txce); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
    checks++; if (tx !== 8'h00 || active !== 1'b0) begin errors++; $display("FAIL reset_tx_active got tx=%h active=%b exp tx=00 active=0", tx, active); end
    release_reset();
    @(posedge clock); #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL grant_edge1 got=%b exp=0000", grant); end
    @(posedge clock); #1;
    checks++; if (grant !== 4'b0001 || active !== 1'b1) begin errors++; $display("FAIL grant_edge2 got grant=%b active=%b exp 0001 1", grant, active); end
  endtask

  task automatic test_message();
    int t;
    do_reset();
    set_msg(0, 3, 8'hA1, 8'hA2, 8'hA3, 8'h00, 1'b0);
    bsy_mode = 1'b1;
    bsy_len  = 20;
    en = 4'b0001;
    release_reset();
    t = 0;
    while (!(n_txce >= 3 && !active) && t < 400) begin @(negedge clock); t++; end
    checks++; if (!(n_txce >= 3 && !active)) begin errors++; $display("FAIL msg_timeout got txce=%0d active=%b exp 3 0", n_txce, active); end
    repeat (30) @(negedge clock);
    checks++; if (n_txce !== 3) begin errors++; $display("FAIL msg_txce_count got=%0d exp=3", n_txce); end
    checks++; if (txce_tx[0] !== 8'hA1 || txce_tx[1] !== 8'hA2 || txce_tx[2] !== 8'hA3)
      begin errors++; $display("FAIL msg_bytes got=%h %h %h exp=a1 a2 a3", txce_tx[0], txce_tx[1], txce_tx[2]); end
    checks++; if (txce_cyc[1] - txce_cyc[0] < 20 || txce_cyc[2] - txce_cyc[1] < 20)
      begin errors++; $display("FAIL msg_gap got=%0d %0d exp>=20", txce_cyc[1] - txce_cyc[0], txce_cyc[2] - txce_cyc[1]); end
    checks++; if (grant !== 4'b0000 || ack_cnt[0] !== 3) begin errors++; $display("FAIL msg_end got grant=%b acks=%0d exp 0000 3", grant, ack_cnt[0]); end
    checks++; if (tx !== 8'hA3) begin errors++; $display("FAIL msg_tx_hold got=%h exp=a3", tx); end
    checks++; if (both_err !== 0) begin errors++; $display("FAIL ack_txce_overlap got=%0d exp=0", both_err); end
  endtask

  task automatic test_round_robin();
    int t;
    logic [N-1:0] exp_g;
    do_reset();
    for (int i = 0; i < N; i++) set_msg(i, 1, 8'h10 + 8'(i), 8'h00, 8'h00, 8'h00, 1'b1);
    bsy_mode = 1'b1;
    bsy_len  = 4;
    en = 4'b1111;
    release_reset();
    t = 0;
    while (n_grant < 5 && t < 600) begin @(negedge clock); t++; end
    checks++; if (n_grant < 5) begin errors++; $display("FAIL rr_timeout got grants=%0d exp=5", n_grant); end
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      checks++; if (grant_log[i] !== exp_g) begin errors++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, grant_log[i], exp_g); end
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (ack_cnt[i] !== 1) begin errors++; $display("FAIL rr_ack[%0d] got=%0d exp=1", i, ack_cnt[i]); end
    end
    for (int i = 0; i < N; i++) begin
      checks++; if (txce_tx[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rr_byte[%0d] got=%h exp=%h", i, txce_tx[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_bsy_timeout();
    int t;
    do_reset();
    set_msg(0, 4, 8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
    bsy_mode = 1'b0;
    en = 4'b0001;
    release_reset();
    t = 0;
    while (!(n_txce >= 4 && !active) && t < 400) begin @(negedge clock); t++; end
    checks++; if (!(n_txce >= 4 && !active)) begin errors++; $display("FAIL to_timeout got txce=%0d active=%b exp 4 0", n_txce, active); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (txce_cyc[i] - txce_cyc[i-1] !== TO + 3)
        begin errors++; $display("FAIL to_interval[%0d] got=%0d exp=%0d", i, txce_cyc[i] - txce_cyc[i-1], TO + 3); end
    end
    checks++; if (txce_tx[3] !== 8'h34 || grant !== 4'b0000) begin errors++; $display("FAIL to_end got tx=%h grant=%b exp 34 0000", txce_tx[3], grant); end
    bsy_mode = 1'b1;
  endtask

  task automatic test_no_preempt();
    int t;
    int txce_at_grant;
    int acks_at_grant;
    do_reset();
    set_msg(2, 4, 8'h51, 8'h52, 8'h53, 8'h54, 1'b0);
    set_msg(1, 1, 8'h61, 8'h00, 8'h00, 8'h00, 1'b0);
    bsy_mode = 1'b1;
    bsy_len  = 6;
    en = 4'b0100;
    release_reset();
    t = 0;
    while (ack_cnt[2] < 2 && t < 300) begin @(negedge clock); t++; end
    checks++; if (ack_cnt[2] < 2) begin errors++; $display("FAIL np_timeout1 got acks=%0d exp=2", ack_cnt[2]); end
    en = 4'b0110;
    t = 0;
    while (n_grant < 2 && t < 400) begin @(negedge clock); t++; end
    txce_at_grant = n_txce;
    acks_at_grant = ack_cnt[2];
    checks++; if (grant_log[0] !== 4'b0100 || grant_log[1] !== 4'b0010)
      begin errors++; $display("FAIL np_order got=%b %b exp=0100 0010", grant_log[0], grant_log[1]); end
    checks++; if (txce_at_grant !== 4 || acks_at_grant !== 4)
      begin errors++; $display("FAIL np_owner_done got txce=%0d acks=%0d exp 4 4", txce_at_grant, acks_at_grant); end
    t = 0;
    while (n_txce < 5 && t < 200) begin @(negedge clock); t++; end
    checks++; if (txce_tx[4] !== 8'h61 || txce_tx[3] !== 8'h54)
      begin errors++; $display("FAIL np_bytes got=%h %h exp=54 61", txce_tx[3], txce_tx[4]); end
  endtask

  task automatic test_reset_midmsg();
    int t;
    bit early;
    do_reset();
    set_msg(1, 2, 8'h71, 8'h72, 8'h00, 8'h00, 1'b0);
    set_msg(2, 2, 8'h81, 8'h82, 8'h00, 8'h00, 1'b0);
    set_msg(3, 2, 8'h91, 8'h92, 8'h00, 8'h00, 1'b0);
    bsy_mode = 1'b1;
    bsy_len  = 10;
    en = 4'b1110;
    release_reset();
    t = 0;
    while (!(grant == 4'b0100 && bsy) && t < 400) begin @(negedge clock); t++; end
    checks++; if (!(grant == 4'b0100 && bsy)) begin errors++; $display("FAIL rm_timeout got grant=%b bsy=%b exp 0100 1", grant, bsy); end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || active !== 1'b0) begin errors++; $display("FAIL rm_async got grant=%b active=%b exp 0000 0", grant, active); end
    checks++; if (txce !== 1'b0 || req_ack !== 4'b0000 || tx !== 8'h00)
      begin errors++; $display("FAIL rm_outputs got txce=%b ack=%b tx=%h exp 0 0000 00", txce, req_ack, tx); end
    set_msg(0, 1, 8'hA0, 8'h00, 8'h00, 8'h00, 1'b0);
    en = 4'b1111;
    @(negedge clock);
    release_reset();
    early = 1'b0;
    t = 0;
    while (bsy && t < 40) begin
      @(negedge clock);
      if (bsy && grant != '0) early = 1'b1;
      t++;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL rm_bsy_hold got=granted exp=idle while bsy"); end
    t = 0;
    while (n_grant < 1 && t < 100) begin @(negedge clock); t++; end
    checks++; if (n_grant < 1 || grant_log[0] !== 4'b0001)
      begin errors++; $display("FAIL rm_rearb got n=%0d grant=%b exp 1 0001", n_grant, grant_log[0]); end
  endtask

  initial begin
    test_reset();
    test_message();
    test_round_robin();
    test_bsy_timeout();
    test_no_preempt();
    test_reset_midmsg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
